// File: rtl/mem_req_arbiter_pkg.sv
// Shared CPU definitions for the memory request arbiter: FSM states,
// MIPS-style segment codes, access size encodings and owner ids.
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    // Top address nibble values of the unmapped kernel segments
    localparam logic [3:0] SEG_KSEG0_LO = 4'h8;
    localparam logic [3:0] SEG_KSEG0_HI = 4'h9;
    localparam logic [3:0] SEG_KSEG1_LO = 4'hA;
    localparam logic [3:0] SEG_KSEG1_HI = 4'hB;

    // Bus access size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Which requester owns the outstanding transaction
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    function automatic logic is_kseg0(input logic [3:0] seg);
        return (seg == SEG_KSEG0_LO) || (seg == SEG_KSEG0_HI);
    endfunction

    function automatic logic is_kseg1(input logic [3:0] seg);
        return (seg == SEG_KSEG1_LO) || (seg == SEG_KSEG1_HI);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_va2pa.sv
// Fixed virtual-to-physical mapping: kseg0/kseg1 fold onto the low 512 MB,
// kseg1 is uncached, every other address passes through untouched.
module mem_req_arbiter_va2pa
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr,
    output logic              uncached
);

    logic [3:0] seg;

    assign seg = vaddr[ADDR_W-1 -: 4];

    // Clear the three segment-select bits for the unmapped kernel segments
    always_comb begin
        paddr = vaddr;
        if (is_kseg0(seg) || is_kseg1(seg)) begin
            paddr[ADDR_W-1 -: 3] = 3'b000;
        end
    end

    assign uncached = is_kseg1(seg);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the instruction and data request ports onto a single memory
// bus with one transaction outstanding. Data has priority, but instruction
// fetch is forced through after STARVE_MAX consecutive data grants.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_uncached,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e        state;
    arb_state_e        state_next;

    logic              owner;
    logic              lat_wr;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  starve_cnt;

    logic              grant;
    logic              grant_inst;

    // A grant is only ever taken in IDLE; inst wins alone or once starved
    always_comb begin
        grant      = (state == ST_IDLE) && (inst_req || data_req);
        grant_inst = inst_req && (!data_req || (starve_cnt == CNT_MAX));
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; strobes go only to the owner
    always_comb begin
        state_next   = state;
        m_req        = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_req = 1'b1;
                if (m_addr_ok) begin
                    state_next   = ST_WAIT;
                    inst_addr_ok = (owner == OWNER_INST);
                    data_addr_ok = (owner == OWNER_DATA);
                end
            end
            ST_WAIT: begin
                if (m_data_ok) begin
                    state_next   = ST_IDLE;
                    inst_data_ok = (owner == OWNER_INST);
                    data_data_ok = (owner == OWNER_DATA);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's request fields at the grant and hold them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner     <= OWNER_INST;
            lat_wr    <= 1'b0;
            lat_size  <= SIZE_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            if (grant_inst) begin
                owner     <= OWNER_INST;
                lat_wr    <= 1'b0;
                lat_size  <= SIZE_WORD;
                lat_addr  <= inst_addr;
                lat_wdata <= '0;
            end else begin
                owner     <= OWNER_DATA;
                lat_wr    <= data_wr;
                lat_size  <= data_size;
                lat_addr  <= data_addr;
                lat_wdata <= data_wdata;
            end
        end
    end

    // Count data grants that overtook a waiting inst request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_inst || !inst_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    mem_req_arbiter_va2pa #(
        .ADDR_W (ADDR_W)
    ) u_va2pa (
        .vaddr    (lat_addr),
        .paddr    (m_addr),
        .uncached (m_uncached)
    );

    assign m_wr       = lat_wr;
    assign m_size     = lat_size;
    assign m_wdata    = lat_wdata;
    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

endmodule
